// File: rtl/rom_cmd_engine.sv
// Command-driven ROM reader: parses READ/BURST commands from a byte FIFO and
// streams status, data and (with ROM_CHECKSUM_EN defined) an XOR checksum byte.
module rom_cmd_engine #(
    parameter int ADDR_BYTES = 2,
    parameter int DATA_BYTES = 4,
    parameter int ROM_DEPTH  = 1024,
    parameter int MAX_BURST  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_almost_empty,
    output logic                         cmd_rd_en,
    input  logic [7:0]                   cmd_din,
    input  logic                         res_almost_full,
    output logic                         res_wr_en,
    output logic [7:0]                   res_dout,
    output logic                         rom_rd_en,
    output logic [$clog2(ROM_DEPTH)-1:0] rom_addr,
    input  logic [DATA_BYTES*8-1:0]      rom_rdata,
    output logic                         busy
);

    localparam int AW  = $clog2(ROM_DEPTH);
    localparam int AWB = ADDR_BYTES * 8;
    localparam int DW  = DATA_BYTES * 8;

    localparam logic [7:0] OP_READ   = 8'h01;
    localparam logic [7:0] OP_BURST  = 8'h02;
    localparam logic [7:0] ST_OK     = 8'h00;
    localparam logic [7:0] ST_BAD_OP = 8'hE0;
    localparam logic [7:0] ST_RANGE  = 8'hE1;
    localparam logic [7:0] ST_LEN    = 8'hE2;

    localparam logic [AWB:0] DEPTH_W = (AWB+1)'(ROM_DEPTH);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        GET_OP    = 4'd1,
        GET_ADDR  = 4'd2,
        GET_LEN   = 4'd3,
        CHECK     = 4'd4,
        ROM_RD    = 4'd5,
        ROM_WAIT  = 4'd6,
        SEND_DATA = 4'd7
`ifdef ROM_CHECKSUM_EN
        ,
        SEND_CRC  = 4'd8
`endif
    } state_t;

    state_t         state_r;
    logic           pend_r;
    logic [7:0]     op_r;
    logic [AWB-1:0] addr_r;
    logic [7:0]     cnt_r;
    logic [7:0]     len_r;
    logic [7:0]     words_left_r;
    logic [7:0]     bidx_r;
    logic [DW-1:0]  word_r;
    logic           rom_rd_en_r;
    logic [AW-1:0]  rom_addr_r;
`ifdef ROM_CHECKSUM_EN
    logic [7:0]     crc_r;

    function automatic logic [7:0] crc_next(input logic [7:0] crc, input logic [7:0] data);
        return crc ^ data;
    endfunction
`endif

    logic [AWB:0]   end_s;
    logic [AWB-1:0] addr_nxt_s;
    logic [7:0]     status_s;
    logic           cmd_rd_en_s;
    logic           res_wr_en_s;
    logic [7:0]     res_dout_s;

    // Command validation, evaluated from the fully captured command fields
    always_comb begin
        end_s      = {1'b0, addr_r} + (AWB+1)'(len_r);
        addr_nxt_s = addr_r + AWB'(1);
        if ((op_r != OP_READ) && (op_r != OP_BURST)) begin
            status_s = ST_BAD_OP;
        end else if (({1'b0, addr_r} >= DEPTH_W) || (end_s > DEPTH_W)) begin
            status_s = ST_RANGE;
        end else if ((len_r == 8'd0) || (len_r > 8'(MAX_BURST))) begin
            status_s = ST_LEN;
        end else begin
            status_s = ST_OK;
        end
    end

    // FIFO strobes are gated by the live flags so the pop/push rules hold cycle-exactly
    always_comb begin
        cmd_rd_en_s = 1'b0;
        res_wr_en_s = 1'b0;
        res_dout_s  = 8'h00;
        case (state_r)
            GET_OP, GET_ADDR, GET_LEN: begin
                cmd_rd_en_s = !pend_r && !cmd_almost_empty;
            end
            CHECK: begin
                res_wr_en_s = !res_almost_full;
                res_dout_s  = status_s;
            end
            SEND_DATA: begin
                res_wr_en_s = !res_almost_full;
                res_dout_s  = word_r[7:0];
            end
`ifdef ROM_CHECKSUM_EN
            SEND_CRC: begin
                res_wr_en_s = !res_almost_full;
                res_dout_s  = crc_r;
            end
`endif
            default: begin
                cmd_rd_en_s = 1'b0;
                res_wr_en_s = 1'b0;
                res_dout_s  = 8'h00;
            end
        endcase
    end

    // Main sequencer: command parsing, ROM access and response byte stepping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            pend_r       <= 1'b0;
            op_r         <= 8'h00;
            addr_r       <= '0;
            cnt_r        <= 8'd0;
            len_r        <= 8'd0;
            words_left_r <= 8'd0;
            bidx_r       <= 8'd0;
            word_r       <= '0;
            rom_rd_en_r  <= 1'b0;
            rom_addr_r   <= '0;
`ifdef ROM_CHECKSUM_EN
            crc_r        <= 8'h00;
`endif
        end else begin
            rom_rd_en_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (!cmd_almost_empty) begin
                        state_r <= GET_OP;
                    end
                end
                GET_OP: begin
                    if (pend_r) begin
                        pend_r <= 1'b0;
                        op_r   <= cmd_din;
                        addr_r <= '0;
                        cnt_r  <= 8'd0;
                        len_r  <= 8'd1;
                        // an unknown opcode goes straight to CHECK without consuming more bytes
                        if ((cmd_din == OP_READ) || (cmd_din == OP_BURST)) begin
                            state_r <= GET_ADDR;
                        end else begin
                            state_r <= CHECK;
                        end
                    end else if (cmd_rd_en_s) begin
                        pend_r <= 1'b1;
                    end
                end
                GET_ADDR: begin
                    if (pend_r) begin
                        pend_r <= 1'b0;
                        addr_r <= AWB'({cmd_din, addr_r} >> 8'd8);
                        cnt_r  <= cnt_r + 8'd1;
                        if (cnt_r == 8'(ADDR_BYTES - 1)) begin
                            state_r <= (op_r == OP_BURST) ? GET_LEN : CHECK;
                        end
                    end else if (cmd_rd_en_s) begin
                        pend_r <= 1'b1;
                    end
                end
                GET_LEN: begin
                    if (pend_r) begin
                        pend_r  <= 1'b0;
                        len_r   <= cmd_din;
                        state_r <= CHECK;
                    end else if (cmd_rd_en_s) begin
                        pend_r <= 1'b1;
                    end
                end
                CHECK: begin
                    if (res_wr_en_s) begin
                        if (status_s == ST_OK) begin
                            state_r      <= ROM_RD;
                            rom_rd_en_r  <= 1'b1;
                            rom_addr_r   <= addr_r[AW-1:0];
                            words_left_r <= len_r;
`ifdef ROM_CHECKSUM_EN
                            crc_r        <= 8'h00;
`endif
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                end
                ROM_RD: begin
                    state_r <= ROM_WAIT;
                end
                ROM_WAIT: begin
                    word_r  <= rom_rdata;
                    bidx_r  <= 8'd0;
                    state_r <= SEND_DATA;
                end
                SEND_DATA: begin
                    if (res_wr_en_s) begin
                        word_r <= word_r >> 8'd8;
`ifdef ROM_CHECKSUM_EN
                        crc_r  <= crc_next(crc_r, word_r[7:0]);
`endif
                        if (bidx_r == 8'(DATA_BYTES - 1)) begin
                            addr_r       <= addr_nxt_s;
                            words_left_r <= words_left_r - 8'd1;
                            if (words_left_r == 8'd1) begin
`ifdef ROM_CHECKSUM_EN
                                state_r <= SEND_CRC;
`else
                                state_r <= IDLE;
`endif
                            end else begin
                                state_r     <= ROM_RD;
                                rom_rd_en_r <= 1'b1;
                                rom_addr_r  <= addr_nxt_s[AW-1:0];
                            end
                        end else begin
                            bidx_r <= bidx_r + 8'd1;
                        end
                    end
                end
`ifdef ROM_CHECKSUM_EN
                SEND_CRC: begin
                    if (res_wr_en_s) begin
                        state_r <= IDLE;
                    end
                end
`endif
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign cmd_rd_en = cmd_rd_en_s;
    assign res_wr_en = res_wr_en_s;
    assign res_dout  = res_dout_s;
    assign rom_rd_en = rom_rd_en_r;
    assign rom_addr  = rom_addr_r;
    assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_rom_cmd_engine.sv
// Scoreboard bench for rom_cmd_engine: a command-level model fills expected
// response/ROM-address queues; independent monitors pop and compare.
module tb_rom_cmd_engine;

    localparam int ADDR_BYTES = 2;
    localparam int DATA_BYTES = 4;
    localparam int ROM_DEPTH  = 1024;
    localparam int MAX_BURST  = 16;
    localparam int AW         = $clog2(ROM_DEPTH);

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    cmd_almost_empty = 1'b1;
    logic                    cmd_rd_en;
    logic [7:0]              cmd_din = 8'h00;
    logic                    res_almost_full = 1'b0;
    logic                    res_wr_en;
    logic [7:0]              res_dout;
    logic                    rom_rd_en;
    logic [AW-1:0]           rom_addr;
    logic [DATA_BYTES*8-1:0] rom_rdata = '0;
    logic                    busy;

    rom_cmd_engine #(
        .ADDR_BYTES(ADDR_BYTES), .DATA_BYTES(DATA_BYTES),
        .ROM_DEPTH(ROM_DEPTH), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_almost_empty(cmd_almost_empty), .cmd_rd_en(cmd_rd_en), .cmd_din(cmd_din),
        .res_almost_full(res_almost_full), .res_wr_en(res_wr_en), .res_dout(res_dout),
        .rom_rd_en(rom_rd_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    logic [DATA_BYTES*8-1:0] rom_mem [ROM_DEPTH];

    always @(posedge clk) begin
        if (rom_rd_en) rom_rdata <= rom_mem[rom_addr];
    end

    int         vec_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] cmd_q[$];
    logic [7:0] res_exp_q[$];
    int         rom_exp_q[$];
    logic [7:0] rx_log[$];
    longint     rx_t[$];
    longint     last_rd_t = 0;
    bit         gap_en = 1'b0;
    bit         stall_en = 1'b0;
    bit         force_stall = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        vec_cnt++;
        err_cnt++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Command FIFO model: serves a byte the cycle after each pop
    initial begin
        logic [7:0] next_b;
        bit         have_next;
        have_next = 1'b0;
        next_b = 8'h00;
        forever begin
            @(negedge clk);
            if (have_next) begin
                cmd_din = next_b;
                have_next = 1'b0;
            end
            cmd_almost_empty = (cmd_q.size() == 0) || (gap_en && ($urandom_range(0, 2) == 0));
            #1;
            if (cmd_rd_en) begin
                check("cmd_rd_en_legal", cmd_almost_empty, 0);
                if (cmd_q.size() == 0) begin
                    flag("cmd_underflow");
                end else begin
                    next_b = cmd_q.pop_front();
                    have_next = 1'b1;
                    last_rd_t = $time;
                end
            end
        end
    end

    // Response FIFO backpressure
    initial begin
        forever begin
            @(negedge clk);
            res_almost_full = force_stall || (stall_en && ($urandom_range(0, 3) == 0));
        end
    end

    // Monitor: pops expected response bytes and ROM addresses
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (res_wr_en) begin
                check("res_wr_en_legal", res_almost_full, 0);
                if (res_exp_q.size() == 0) flag("unexpected_res_byte");
                else check("res_byte", res_dout, res_exp_q.pop_front());
                rx_log.push_back(res_dout);
                rx_t.push_back($time);
            end
            if (rom_rd_en) begin
                if (rom_exp_q.size() == 0) flag("unexpected_rom_rd");
                else check("rom_addr", rom_addr, rom_exp_q.pop_front());
            end
        end
    end

    // Reference model: command bytes plus the response the spec rules imply
    task automatic issue(input int op, input int addr, input int n);
        int         words;
        logic [7:0] crc;
        logic [DATA_BYTES*8-1:0] w;
        addr = addr & 16'hFFFF;
        cmd_q.push_back(8'(op));
        if (op == 1 || op == 2) begin
            for (int i = 0; i < ADDR_BYTES; i++) cmd_q.push_back(8'(addr >> (8 * i)));
            if (op == 2) cmd_q.push_back(8'(n));
        end
        words = (op == 1) ? 1 : n;
        if (op != 1 && op != 2) begin
            res_exp_q.push_back(8'hE0);
        end else if (addr >= ROM_DEPTH || addr + words > ROM_DEPTH) begin
            res_exp_q.push_back(8'hE1);
        end else if (op == 2 && (n == 0 || n > MAX_BURST)) begin
            res_exp_q.push_back(8'hE2);
        end else begin
            res_exp_q.push_back(8'h00);
            crc = 8'h00;
            for (int k = 0; k < words; k++) begin
                rom_exp_q.push_back(addr + k);
                w = rom_mem[addr + k];
                for (int b = 0; b < DATA_BYTES; b++) begin
                    res_exp_q.push_back(w[8*b +: 8]);
                    crc = crc ^ w[8*b +: 8];
                end
            end
`ifdef ROM_CHECKSUM_EN
            res_exp_q.push_back(crc);
`endif
        end
    endtask

    task automatic wait_done(input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 20000 && !done; c++) begin
            @(negedge clk);
            #2;
            if (cmd_q.size() == 0 && res_exp_q.size() == 0 && rom_exp_q.size() == 0 && !busy)
                done = 1'b1;
        end
        if (!done) flag({name, "_timeout"});
    endtask

    task automatic wait_rx(input int target, input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clk);
            #2;
            if (rx_log.size() >= target) done = 1'b1;
        end
        if (!done) flag({name, "_timeout"});
    endtask

    task automatic check_read5(input string name);
`ifdef ROM_CHECKSUM_EN
        logic [7:0] exp_b [6] = '{8'h00, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h04};
`else
        logic [7:0] exp_b [5] = '{8'h00, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
`endif
        check({name, "_len"}, rx_log.size(), $size(exp_b));
        for (int i = 0; i < $size(exp_b) && i < rx_log.size(); i++)
            check({name, "_byte"}, rx_log[i], exp_b[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int op, addr, n, sel, n0;
        for (int i = 0; i < ROM_DEPTH; i++) rom_mem[i] = $urandom;
        rom_mem[5] = 32'hA1B2C3D4;

        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_cmd_rd_en", cmd_rd_en, 0);
        check("rst_res_wr_en", res_wr_en, 0);
        check("rst_res_dout", res_dout, 0);
        check("rst_rom_rd_en", rom_rd_en, 0);
        check("rst_rom_addr", rom_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // READ of word 5 with exact latency
        rx_log.delete(); rx_t.delete();
        issue(1, 5, 0);
        wait_done("read5");
        check_read5("read5");
        if (rx_t.size() >= 2) begin
            check("lat_status", rx_t[0] - last_rd_t, 20);
            check("lat_data", rx_t[1] - rx_t[0], 30);
        end else begin
            flag("lat_missing");
        end

        // Range boundary at the top of the ROM
        issue(2, 16'h3FE, 3);
        issue(2, 16'h3FE, 2);
        issue(1, 16'h0400, 0);
        wait_done("range");

        // Bad opcode recovery and length errors
        issue(16'h7F, 0, 0);
        issue(1, 5, 0);
        issue(2, 10, 0);
        issue(2, 10, 17);
        issue(2, 10, 16);
        wait_done("errors");

        // 10-cycle stall in the middle of a 4-word burst
        rx_log.delete();
        issue(2, 100, 4);
        wait_rx(7, "stall_pre");
        force_stall = 1'b1;
        @(negedge clk);
        #2;
        n0 = rx_log.size();
        repeat (9) @(negedge clk);
        #2;
        check("stall_no_push", rx_log.size(), n0);
        check("stall_busy", busy, 1);
        force_stall = 1'b0;
        wait_done("stall");
        check("stall_total", rx_log.size(), 1 + 4 * DATA_BYTES
`ifdef ROM_CHECKSUM_EN
              + 1
`endif
              );

        // Randomized commands with command gaps and response backpressure
        gap_en = 1'b1;
        stall_en = 1'b1;
        for (int t = 0; t < 60; t++) begin
            sel = $urandom_range(0, 9);
            op = (sel < 2) ? $urandom_range(3, 255) : ((sel < 5) ? 1 : 2);
            sel = $urandom_range(0, 9);
            addr = (sel < 6) ? $urandom_range(0, ROM_DEPTH - 1)
                 : ((sel < 8) ? $urandom_range(ROM_DEPTH - 24, ROM_DEPTH - 1)
                 : $urandom_range(ROM_DEPTH, 65535));
            n = $urandom_range(0, MAX_BURST + 2);
            issue(op, addr, n);
        end
        wait_done("random");
        gap_en = 1'b0;
        stall_en = 1'b0;

        // Reset during SEND_DATA, then a clean READ
        rx_log.delete();
        issue(2, 200, 8);
        wait_rx(3, "rst_pre");
        check("busy_before_rst", busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_res_wr_en", res_wr_en, 0);
        check("arst_res_dout", res_dout, 0);
        check("arst_rom_rd_en", rom_rd_en, 0);
        check("arst_cmd_rd_en", cmd_rd_en, 0);
        res_exp_q.delete();
        rom_exp_q.delete();
        cmd_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rx_log.delete();
        issue(1, 5, 0);
        wait_done("post_rst");
        check_read5("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
